// File: rtl/fft_pkg.sv
// Shared FFT sample types: block/address types, read-engine states and CCI-P channel 0 structures.
package fft_pkg;

    localparam int RD_DEPTH_DEFAULT = 8;

    typedef logic [63:0]  t_hc_address;
    typedef logic [511:0] t_block;
    typedef logic [5:0]   t_rd_tag;
    typedef logic [26:0]  t_rd_line_cnt;

    typedef enum logic [1:0] {
        S_RD_IDLE,
        S_RD_FETCH,
        S_RD_WAIT,
        S_RD_FINISH
    } t_rd_state;

    typedef logic [57:0] t_ccip_clAddr;
    typedef logic [15:0] t_ccip_mdata;

    typedef enum logic [1:0] {
        eVC_VA  = 2'd0,
        eVC_VL0 = 2'd1,
        eVC_VH0 = 2'd2,
        eVC_VH1 = 2'd3
    } t_ccip_vc;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'd0,
        eCL_LEN_2 = 2'd1,
        eCL_LEN_4 = 2'd3
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eREQ_RDLINE_I = 4'h0,
        eREQ_RDLINE_S = 4'h1
    } t_ccip_c0_req;

    typedef enum logic [3:0] {
        eRSP_RDLINE = 4'h0,
        eRSP_UMSG   = 4'h4
    } t_ccip_c0_rsp;

    typedef struct packed {
        t_ccip_vc     vc_sel;
        logic [1:0]   rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c0_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic [1:0]   rsvd0;
        logic [1:0]   cl_num;
        t_ccip_c0_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        t_block             data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

    // Whole cache lines covering size_bytes; a partial tail counts as a full line.
    function automatic t_rd_line_cnt rd_line_count(input logic [31:0] size_bytes);
        return t_rd_line_cnt'(({1'b0, size_bytes} + 33'd63) >> 6);
    endfunction

endpackage

// File: rtl/fft_rd_engine_if.sv
// In-order cache-line stream from the read engine to the FFT datapath.
interface fft_rd_engine_if;
    logic             valid;
    fft_pkg::t_block  data;
    logic             last;
    logic             ready;

    modport master (output valid, data, last, input ready);
    modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/fft_rd_engine_rob.sv
// Reorder buffer for the read engine: slot storage, pending/filled tracking and the in-order pop port.
module fft_rd_rob
    import fft_pkg::*;
#(
    parameter int RD_DEPTH = RD_DEPTH_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        issue,
    input  logic [$clog2(RD_DEPTH)-1:0] issue_slot,
    input  logic                        rsp_valid,
    input  t_rd_tag                     rsp_tag,
    input  t_block                      rsp_data,
    output logic                        head_valid,
    output t_block                      head_data,
    input  logic                        head_ready,
    output logic                        pop
);

    localparam int IDX_W = $clog2(RD_DEPTH);

    t_block              slot_q [RD_DEPTH];
    logic [RD_DEPTH-1:0] pending_q;
    logic [RD_DEPTH-1:0] filled_q;
    logic [IDX_W-1:0]    head_q;
    logic [IDX_W-1:0]    fill_slot;
    logic                fill;

    // Tags outside the window can never be pending, so they are dropped here too.
    assign fill_slot  = rsp_tag[IDX_W-1:0];
    assign fill       = rsp_valid && (int'(rsp_tag) < RD_DEPTH) && pending_q[fill_slot];

    assign head_valid = filled_q[head_q];
    assign head_data  = slot_q[head_q];
    assign pop        = head_valid && head_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            filled_q  <= '0;
            head_q    <= '0;
        end else begin
            if (clear) begin
                head_q <= '0;
            end else if (pop) begin
                head_q <= head_q + IDX_W'(1);
            end
            for (int i = 0; i < RD_DEPTH; i++) begin
                if (issue && issue_slot == IDX_W'(i)) begin
                    pending_q[i] <= 1'b1;
                end else if (fill && fill_slot == IDX_W'(i)) begin
                    pending_q[i] <= 1'b0;
                end
                if (fill && fill_slot == IDX_W'(i)) begin
                    filled_q[i] <= 1'b1;
                end else if (pop && head_q == IDX_W'(i)) begin
                    filled_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            slot_q[fill_slot] <= rsp_data;
        end
    end

endmodule

// File: rtl/fft_rd_engine.sv
// FFT source read engine: fetches the buffer as cache lines on CCI-P c0 and streams them in address order.
//   state       | meaning
//   S_RD_IDLE   | waiting for start
//   S_RD_FETCH  | issuing line reads within the reorder window
//   S_RD_WAIT   | all reads issued, draining lines to the consumer
//   S_RD_FINISH | transfer complete, done pulse follows
module fft_rd_engine
    import fft_pkg::*;
#(
    parameter int RD_DEPTH = RD_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  t_hc_address      buf_addr,
    input  logic [31:0]      buf_size,
    input  logic             c0_almfull,
    input  t_if_ccip_c0_Rx   rx_c0,
    output t_if_ccip_c0_Tx   tx_c0,
    fft_rd_engine_if.master  blk,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = $clog2(RD_DEPTH);

    t_rd_state          state_q, state_d;
    t_rd_line_cnt       lines_q, issued_q, delivered_q;
    t_rd_line_cnt       in_flight, new_lines;
    t_ccip_clAddr       base_q;
    t_ccip_c0_ReqMemHdr req_hdr;
    t_block             head_data;
    logic               almfull_q;
    logic               issue, last_issue, accept_start;
    logic               rsp_valid, head_valid, pop;
    logic               unused_ok;

    assign new_lines  = rd_line_count(buf_size);
    assign in_flight  = issued_q - delivered_q;
    assign issue      = (state_q == S_RD_FETCH) && (issued_q < lines_q)
                        && (in_flight < t_rd_line_cnt'(RD_DEPTH)) && !almfull_q;
    assign last_issue = issue && (issued_q == lines_q - t_rd_line_cnt'(1));
    assign rsp_valid  = rx_c0.rspValid && (rx_c0.hdr.resp_type == eRSP_RDLINE);

    assign unused_ok  = ^{buf_addr[5:0], rx_c0.hdr.vc_used, rx_c0.hdr.rsvd1, rx_c0.hdr.hit_miss,
                          rx_c0.hdr.rsvd0, rx_c0.hdr.cl_num, rx_c0.hdr.mdata[15:6],
                          rx_c0.mmioRdValid, rx_c0.mmioWrValid};

    always_comb begin
        state_d      = state_q;
        accept_start = 1'b0;
        busy         = (state_q != S_RD_IDLE);
        case (state_q)
            S_RD_IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_d      = (new_lines == '0) ? S_RD_FINISH : S_RD_FETCH;
                end
            end
            S_RD_FETCH: begin
                if (last_issue) begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (delivered_q == lines_q) begin
                    state_d = S_RD_FINISH;
                end
            end
            S_RD_FINISH: begin
                state_d = S_RD_IDLE;
            end
            default: begin
                state_d = S_RD_IDLE;
            end
        endcase
    end

    always_comb begin
        req_hdr          = '0;
        req_hdr.vc_sel   = eVC_VA;
        req_hdr.cl_len   = eCL_LEN_1;
        req_hdr.req_type = eREQ_RDLINE_I;
        req_hdr.address  = base_q + t_ccip_clAddr'(issued_q);
        req_hdr.mdata    = t_ccip_mdata'(issued_q[IDX_W-1:0]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_RD_IDLE;
            lines_q     <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            base_q      <= '0;
            almfull_q   <= 1'b0;
            tx_c0       <= '0;
            done        <= 1'b0;
        end else begin
            state_q   <= state_d;
            almfull_q <= c0_almfull;
            done      <= (state_q == S_RD_FINISH);
            if (accept_start) begin
                lines_q     <= new_lines;
                base_q      <= buf_addr[63:6];
                issued_q    <= '0;
                delivered_q <= '0;
            end else begin
                if (issue) begin
                    issued_q <= issued_q + t_rd_line_cnt'(1);
                end
                if (pop) begin
                    delivered_q <= delivered_q + t_rd_line_cnt'(1);
                end
            end
            tx_c0.valid <= issue;
            if (issue) begin
                tx_c0.hdr <= req_hdr;
            end
        end
    end

    fft_rd_rob #(
        .RD_DEPTH (RD_DEPTH)
    ) u_rob (
        .clk        (clk),
        .reset      (reset),
        .clear      (accept_start),
        .issue      (issue),
        .issue_slot (issued_q[IDX_W-1:0]),
        .rsp_valid  (rsp_valid),
        .rsp_tag    (rx_c0.hdr.mdata[5:0]),
        .rsp_data   (rx_c0.data),
        .head_valid (head_valid),
        .head_data  (head_data),
        .head_ready (blk.ready),
        .pop        (pop)
    );

    assign blk.valid = head_valid;
    assign blk.data  = head_data;
    assign blk.last  = (delivered_q == lines_q - t_rd_line_cnt'(1));

endmodule

// File: tb/tb_fft_rd_engine.sv
// Self-checking bench for fft_rd_engine: host-memory responder model plus an in-order line scoreboard.
`timescale 1ns/1ps
module tb_fft_rd_engine;
    import fft_pkg::*;

    localparam int DEPTH = 8;

    typedef struct {
        t_block data;
        logic   last;
    } t_exp;

    typedef struct {
        logic [31:0] size;
        int          rsp_mode;
        int          ready_mode;
        int          exp_lines;
    } t_vec;

    logic           clk = 1'b0;
    logic           reset, start, c0_almfull, busy, done;
    t_hc_address    buf_addr;
    logic [31:0]    buf_size;
    t_if_ccip_c0_Rx rx_c0;
    t_if_ccip_c0_Tx tx_c0;

    fft_rd_engine_if blk_if();

    fft_rd_engine #(.RD_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .buf_addr   (buf_addr),
        .buf_size   (buf_size),
        .c0_almfull (c0_almfull),
        .rx_c0      (rx_c0),
        .tx_c0      (tx_c0),
        .blk        (blk_if),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_req, n_blk, n_done, req_idx, idle_cnt;
    int rsp_mode, ready_mode;
    t_ccip_clAddr exp_base;
    t_exp sb_q[$];
    t_ccip_c0_ReqMemHdr pend[$];
    t_ccip_c0_ReqMemHdr burst[$];
    t_vec vecs[6];

    function automatic void chk(string name, logic [511:0] act, logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic t_block mem_line(t_ccip_clAddr a);
        logic [31:0] lo;
        lo = a[31:0];
        return {8{lo ^ 32'hC0DE_0000, ~lo}};
    endfunction

    function automatic void send(t_ccip_c0_ReqMemHdr h);
        rx_c0.rspValid       = 1'b1;
        rx_c0.hdr.resp_type  = eRSP_RDLINE;
        rx_c0.hdr.mdata      = h.mdata;
        rx_c0.data           = mem_line(h.address);
    endfunction

    task automatic tick();
        t_ccip_c0_ReqMemHdr h;
        t_exp e;
        int idx;
        @(negedge clk);
        start = 1'b0;
        if (done) n_done++;
        if (tx_c0.valid) begin
            h = tx_c0.hdr;
            chk("req_addr", h.address, exp_base + t_ccip_clAddr'(req_idx));
            chk("req_tag", h.mdata, req_idx % DEPTH);
            chk("req_type", {h.vc_sel, h.cl_len, h.req_type}, {eVC_VA, eCL_LEN_1, eREQ_RDLINE_I});
            req_idx++;
            n_req++;
            pend.push_back(h);
            idle_cnt = 0;
        end else begin
            idle_cnt++;
        end
        rx_c0 = '0;
        case (rsp_mode)
            0: if (pend.size() > 0) send(pend.pop_front());
            1: begin
                if (burst.size() == 0 && (pend.size() == DEPTH || (pend.size() > 0 && idle_cnt >= 16))) begin
                    burst = pend;
                    pend.delete();
                end
                if (burst.size() > 0) send(burst.pop_back());
            end
            2: begin
                if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
                    idx = int'($urandom_range(0, pend.size() - 1));
                    send(pend[idx]);
                    pend.delete(idx);
                end else if ($urandom_range(0, 3) == 0) begin
                    // junk that must be dropped: foreign response type, or a tag outside the window
                    rx_c0.rspValid = 1'b1;
                    rx_c0.data     = '1;
                    if ($urandom_range(0, 1) == 1) begin
                        rx_c0.hdr.resp_type = eRSP_UMSG;
                        rx_c0.hdr.mdata     = 16'($urandom_range(0, DEPTH - 1));
                    end else begin
                        rx_c0.hdr.resp_type = eRSP_RDLINE;
                        rx_c0.hdr.mdata     = 16'($urandom_range(DEPTH, 63));
                    end
                end
            end
            default: ;
        endcase
        case (ready_mode)
            0:       blk_if.ready = 1'b1;
            1:       blk_if.ready = 1'($urandom_range(0, 1));
            default: blk_if.ready = 1'b0;
        endcase
        if (blk_if.valid && blk_if.ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_blk: got valid line %0h expected no line", blk_if.data);
            end else begin
                e = sb_q.pop_front();
                chk("blk_data", blk_if.data, e.data);
                chk("blk_last", blk_if.last, e.last);
            end
            n_blk++;
        end else if (blk_if.valid && sb_q.size() > 0) begin
            chk("blk_hold_data", blk_if.data, sb_q[0].data);
            chk("blk_hold_last", blk_if.last, sb_q[0].last);
        end
    endtask

    task automatic kick(t_hc_address a, logic [31:0] sz);
        int lines;
        t_exp e;
        lines    = (int'(sz) + 63) / 64;
        buf_addr = a;
        buf_size = sz;
        start    = 1'b1;
        exp_base = a[63:6];
        req_idx  = 0;
        n_req    = 0;
        n_blk    = 0;
        n_done   = 0;
        idle_cnt = 0;
        pend.delete();
        burst.delete();
        for (int n = 0; n < lines; n++) begin
            e.data = mem_line(exp_base + t_ccip_clAddr'(n));
            e.last = (n == lines - 1);
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_done(int budget);
        int k;
        k = 0;
        while (n_done == 0 && k < budget) begin
            tick();
            k++;
        end
        n_cmp++;
        if (n_done == 0) begin
            n_err++;
            $display("FAIL done_timeout: done=0 after %0d cycles, required 1", budget);
        end
    endtask

    task automatic end_checks(int exp_lines);
        repeat (4) tick();
        chk("n_req", n_req, exp_lines);
        chk("n_blk", n_blk, exp_lines);
        chk("done_pulses", n_done, 1);
        chk("sb_drained", sb_q.size(), 0);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, base_req;
        vecs[0] = '{32'd256,  0, 0, 4};
        vecs[1] = '{32'd1000, 1, 0, 16};
        vecs[2] = '{32'd64,   0, 0, 1};
        vecs[3] = '{32'd65,   2, 1, 2};
        vecs[4] = '{32'd2373, 2, 1, 38};
        vecs[5] = '{32'd512,  1, 1, 8};

        reset = 1'b1; start = 1'b0; c0_almfull = 1'b0;
        buf_addr = '0; buf_size = '0; rx_c0 = '0; blk_if.ready = 1'b0;
        rsp_mode = 0; ready_mode = 0;
        n_req = 0; n_blk = 0; n_done = 0; req_idx = 0; idle_cnt = 0; exp_base = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tx_valid", tx_c0.valid, 0);
        chk("rst_blk_valid", blk_if.valid, 0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            rsp_mode   = vecs[i].rsp_mode;
            ready_mode = vecs[i].ready_mode;
            kick(64'h1000_0000 + 64'(i) * 64'h1_0000, vecs[i].size);
            wait_done(4000);
            end_checks(vecs[i].exp_lines);
        end

        // consumer stalled: window fills with exactly DEPTH requests
        rsp_mode = 0; ready_mode = 2;
        kick(64'h2000_0000, 32'd1280);
        repeat (40) tick();
        chk("stall_req", n_req, 8);
        chk("stall_valid", blk_if.valid, 1);
        chk("stall_blk", n_blk, 0);
        ready_mode = 0;
        wait_done(4000);
        end_checks(20);

        // almfull held for 10 cycles mid-fetch
        rsp_mode = 0; ready_mode = 0;
        kick(64'h3000_0040, 32'd2560);
        repeat (3) tick();
        c0_almfull = 1'b1;
        base_req   = n_req;
        repeat (10) tick();
        n_cmp++;
        if (n_req - base_req > 1) begin
            n_err++;
            $display("FAIL almfull_reqs: got %0d requests expected at most 1", n_req - base_req);
        end
        c0_almfull = 1'b0;
        wait_done(4000);
        end_checks(40);

        // zero-length transfer
        kick(64'h4000_0000, 32'd0);
        tick();
        chk("zero_done_early", done, 0);
        chk("zero_busy", busy, 1);
        tick();
        chk("zero_done", done, 1);
        tick();
        chk("zero_done_pulse", done, 0);
        chk("zero_busy_after", busy, 0);
        chk("zero_req", n_req, 0);
        chk("zero_blk", n_blk, 0);

        // start while busy is ignored
        kick(64'h5000_0000, 32'd256);
        repeat (3) tick();
        buf_addr = 64'h6000_0000;
        buf_size = 32'd640;
        start    = 1'b1;
        wait_done(4000);
        end_checks(4);

        // reset with 5 reads outstanding, then stale responses
        rsp_mode = 3;
        kick(64'h7000_0000, 32'd1024);
        k = 0;
        while (n_req < 5 && k < 100) begin
            tick();
            k++;
        end
        chk("rst_mid_reqs", n_req, 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb_q.delete();
        rsp_mode = 0;
        repeat (7) begin
            tick();
            chk("stale_blk_valid", blk_if.valid, 0);
        end
        chk("stale_busy", busy, 0);
        chk("stale_reqs", n_req, 5);
        chk("stale_blk", n_blk, 0);
        kick(64'h8000_0000, 32'd128);
        wait_done(1000);
        end_checks(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
